// File: rtl/pam_tx_pkg.sv
// Shared types and helpers for the PAM frame transmitter.
//   state_e      : frame FSM states
//   PN7_TAPS     : feedback taps of the x^7 + x^6 + 1 preamble generator
//   MAX_KEEP     : widest tkeep handled by popcount (DATA_WIDTH <= 128)
//   pam_mid      : offset-binary mid-scale code for a given DA width
//   gray2bin     : Gray to binary conversion of a symbol (up to 4 bits)
//   pam_step     : DA code distance between adjacent PAM levels
//   popcount     : number of enabled bytes in a tkeep vector
//   sym_per_bits : whole symbols carried by a number of payload bits
package pam_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_PAYLOAD,
    ST_GAP
  } state_e;

  localparam logic [6:0]  PN7_TAPS = 7'h60;
  localparam int unsigned MAX_KEEP = 16;

  function automatic logic [31:0] pam_mid(input int unsigned aw);
    return 32'd1 << (aw - 1);
  endfunction

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // The divisors are constants per branch, so this folds to a small mux.
  function automatic logic [31:0] pam_step(input logic [2:0] bps, input int unsigned aw);
    logic [31:0] full;
    full = (32'd1 << aw) - 32'd1;
    case (bps)
      3'd1:    return full;
      3'd2:    return full / 32'd3;
      3'd3:    return full / 32'd7;
      default: return full / 32'd15;
    endcase
  endfunction

  function automatic logic [4:0] popcount(input logic [MAX_KEEP-1:0] keep);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_KEEP; i++) n = n + 5'(keep[i]);
    return n;
  endfunction

  function automatic logic [7:0] sym_per_bits(input logic [10:0] nbits, input logic [2:0] bps);
    case (bps)
      3'd1:    return 8'(nbits);
      3'd2:    return 8'(nbits >> 1);
      3'd3:    return 8'(nbits / 11'd3);
      default: return 8'(nbits >> 2);
    endcase
  endfunction

endpackage

// File: rtl/pam_frame_tx_if.sv
// AXI-Stream payload channel into the PAM frame transmitter.
//   tdata  : payload word
//   tlast  : last word of the frame
//   tkeep  : byte enables, contiguous from byte 0, used on the tlast word
//   tvalid : word valid (source)
//   tready : word accepted when tvalid & tready (sink)
interface pam_frame_tx_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic                    tlast;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tlast, tkeep, tvalid, input tready);
  modport slave  (input tdata, tlast, tkeep, tvalid, output tready);
endinterface

// File: rtl/pam_pn_gen.sv
// PN7 preamble generator (x^7 + x^6 + 1), reloaded with SEED at each frame.
//   clk, arst_n : clock, asynchronous active-low reset
//   load        : reload SEED (takes priority over adv)
//   adv         : advance one symbol
//   next_bit    : header bit of the symbol that follows the next advance
module pam_pn_gen
  import pam_tx_pkg::*;
#(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic clk,
  input  logic arst_n,
  input  logic load,
  input  logic adv,
  output logic next_bit
);

  logic [6:0] lfsr_q, lfsr_d, lfsr_adv;

  always_comb begin
    lfsr_adv = {lfsr_q[5:0], ^(lfsr_q & PN7_TAPS)};
    lfsr_d   = lfsr_q;
    if (load)     lfsr_d = SEED;
    else if (adv) lfsr_d = lfsr_adv;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  // The sample register is loaded one cycle ahead, so it needs the MSB
  // the register will hold after this advance.
  assign next_bit = lfsr_adv[6];

endmodule

// File: rtl/pam_frame_tx.sv
// PAM frame transmitter: PN7 preamble, Gray-coded PAM-2/4/8/16 payload taken
// LSB-first from AXI-Stream words, then an idle gap. One DA sample per clock.
//   clk, arst_n : clock, asynchronous active-low reset
//   M_AXIS      : payload stream (slave side)
//   cfg_bps     : bits per symbol 1..4 (others -> 2), latched at frame start
//   cfg_osr     : samples per symbol (0 -> 1), latched at frame start
//   sent_data   : registered DA sample, offset binary
//   sent_valid  : high on header and payload samples
//   frame_busy  : high whenever a frame is in progress
//   underrun    : sticky, payload starved mid-frame; cleared at frame start
module pam_frame_tx
  import pam_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned AD_CVER_WIDTH = 12,
  parameter int unsigned HEAD_LEN      = 64,
  parameter int unsigned GAP_LEN       = 16,
  parameter logic [6:0]  LFSR_SEED     = 7'h7F
) (
  input  logic                     clk,
  input  logic                     arst_n,
  pam_frame_tx_if.slave            M_AXIS,
  input  logic [2:0]               cfg_bps,
  input  logic [7:0]               cfg_osr,
  output logic [AD_CVER_WIDTH-1:0] sent_data,
  output logic                     sent_valid,
  output logic                     frame_busy,
  output logic                     underrun
);

  localparam int unsigned HW = $clog2(HEAD_LEN + 1);
  localparam int unsigned GW = $clog2(GAP_LEN + 2);
  localparam logic [AD_CVER_WIDTH-1:0] MID  = AD_CVER_WIDTH'(pam_mid(AD_CVER_WIDTH));
  localparam logic [AD_CVER_WIDTH-1:0] FULL = '1;

  function automatic logic [AD_CVER_WIDTH-1:0] pam_sample(input logic [3:0] raw,
                                                          input logic [2:0] bps);
    logic [3:0]  mask;
    logic [3:0]  k;
    logic [31:0] prod;
    mask = 4'((5'd1 << bps) - 5'd1);
    k    = gray2bin(raw & mask);
    prod = 32'(k) * pam_step(bps, AD_CVER_WIDTH);
    return AD_CVER_WIDTH'(prod);
  endfunction

  state_e                   state_q, state_d;
  logic [7:0]               rep_q, rep_d, osr_q, osr_d, nsym_q, nsym_d;
  logic [HW-1:0]            hsym_q, hsym_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic [2:0]               bps_q, bps_d;
  logic                     last_q, last_d, wait_q, wait_d, underrun_q, underrun_d;
  logic                     valid_q, valid_d;
  logic [AD_CVER_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;

  logic       rep_end, head_end, word_end, take_word, end_frame;
  logic       lfsr_load, lfsr_adv, pn_next;
  logic [2:0] bps_in;
  logic [7:0] osr_in, n_acc;

  pam_pn_gen #(.SEED(LFSR_SEED)) u_pn (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (lfsr_load),
    .adv      (lfsr_adv),
    .next_bit (pn_next)
  );

  assign bps_in   = (cfg_bps >= 3'd1 && cfg_bps <= 3'd4) ? cfg_bps : 3'd2;
  assign osr_in   = (cfg_osr == 8'd0) ? 8'd1 : cfg_osr;
  assign rep_end  = (rep_q == osr_q - 8'd1);
  assign head_end = (state_q == ST_HEAD) && rep_end && (hsym_q == HW'(HEAD_LEN - 1));
  assign word_end = (state_q == ST_PAYLOAD) && !wait_q && rep_end && (nsym_q == 8'd1);
  // Symbols carried by the word on the bus if it is taken this cycle.
  assign n_acc = M_AXIS.tlast
               ? sym_per_bits(11'(popcount(MAX_KEEP'(M_AXIS.tkeep))) << 3, bps_q)
               : sym_per_bits(11'(DATA_WIDTH), bps_q);

  assign M_AXIS.tready = head_end || (word_end && !last_q) ||
                         ((state_q == ST_PAYLOAD) && wait_q);

  always_comb begin
    state_d    = state_q;
    rep_d      = rep_q;
    osr_d      = osr_q;
    nsym_d     = nsym_q;
    hsym_d     = hsym_q;
    gap_d      = gap_q;
    bps_d      = bps_q;
    last_d     = last_q;
    wait_d     = wait_q;
    underrun_d = underrun_q;
    valid_d    = valid_q;
    data_d     = data_q;
    word_d     = word_q;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    take_word  = 1'b0;
    end_frame  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        data_d  = MID;
        valid_d = 1'b0;
        if (M_AXIS.tvalid) begin
          state_d    = ST_HEAD;
          bps_d      = bps_in;
          osr_d      = osr_in;
          lfsr_load  = 1'b1;
          underrun_d = 1'b0;
          hsym_d     = '0;
          rep_d      = '0;
          data_d     = LFSR_SEED[6] ? FULL : '0;
          valid_d    = 1'b1;
        end
      end
      ST_HEAD: begin
        if (!rep_end) begin
          rep_d = rep_q + 8'd1;
        end else if (!head_end) begin
          rep_d    = '0;
          hsym_d   = hsym_q + HW'(1);
          lfsr_adv = 1'b1;
          data_d   = pn_next ? FULL : '0;
        end else begin
          take_word = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (wait_q) begin
          take_word = 1'b1;
        end else if (!rep_end) begin
          rep_d = rep_q + 8'd1;
        end else if (nsym_q != 8'd1) begin
          rep_d  = '0;
          nsym_d = nsym_q - 8'd1;
          word_d = word_q >> bps_q;
          data_d = pam_sample(word_d[3:0], bps_q);
        end else if (!last_q) begin
          take_word = 1'b1;
        end else begin
          end_frame = 1'b1;
        end
      end
      default: begin
        if (gap_q + GW'(1) == GW'(GAP_LEN)) state_d = ST_IDLE;
        else                                gap_d   = gap_q + GW'(1);
      end
    endcase

    // Word boundary: either load the next word or sit at mid-scale until it
    // arrives. A tlast word with no whole symbol ends the frame at once.
    if (take_word) begin
      if (M_AXIS.tvalid) begin
        if (n_acc == 8'd0) begin
          end_frame = 1'b1;
        end else begin
          state_d = ST_PAYLOAD;
          wait_d  = 1'b0;
          word_d  = M_AXIS.tdata;
          nsym_d  = n_acc;
          last_d  = M_AXIS.tlast;
          rep_d   = '0;
          data_d  = pam_sample(M_AXIS.tdata[3:0], bps_q);
          valid_d = 1'b1;
        end
      end else begin
        state_d    = ST_PAYLOAD;
        wait_d     = 1'b1;
        underrun_d = 1'b1;
        data_d     = MID;
        valid_d    = 1'b0;
      end
    end

    if (end_frame) begin
      state_d = (GAP_LEN == 0) ? ST_IDLE : ST_GAP;
      gap_d   = '0;
      wait_d  = 1'b0;
      data_d  = MID;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      rep_q      <= '0;
      osr_q      <= 8'd1;
      nsym_q     <= '0;
      hsym_q     <= '0;
      gap_q      <= '0;
      bps_q      <= 3'd2;
      last_q     <= 1'b0;
      wait_q     <= 1'b0;
      underrun_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= MID;
    end else begin
      state_q    <= state_d;
      rep_q      <= rep_d;
      osr_q      <= osr_d;
      nsym_q     <= nsym_d;
      hsym_q     <= hsym_d;
      gap_q      <= gap_d;
      bps_q      <= bps_d;
      last_q     <= last_d;
      wait_q     <= wait_d;
      underrun_q <= underrun_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  // Payload word shifter carries data only; it is always loaded before use.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign sent_data  = data_q;
  assign sent_valid = valid_q;
  assign frame_busy = (state_q != ST_IDLE);
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_pam_frame_tx.sv
// Directed bench for pam_frame_tx with default parameters
// (DATA_WIDTH 32, AD_CVER_WIDTH 12, HEAD_LEN 64, GAP_LEN 16, seed 7F).
module tb_pam_frame_tx;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [2:0]  cfg_bps;
  logic [7:0]  cfg_osr;
  logic [11:0] sent_data;
  logic        sent_valid, frame_busy, underrun;
  int          checks = 0;
  int          passes = 0;

  pam_frame_tx_if #(.DATA_WIDTH(32)) axis();

  pam_frame_tx dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .M_AXIS     (axis),
    .cfg_bps    (cfg_bps),
    .cfg_osr    (cfg_osr),
    .sent_data  (sent_data),
    .sent_valid (sent_valid),
    .frame_busy (frame_busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Reference PN7 header level for header symbol n, seed 7F.
  function automatic logic [11:0] hdr_exp(input int n);
    logic [6:0] r;
    r = 7'h7F;
    for (int i = 0; i < n; i++) r = {r[5:0], r[6] ^ r[5]};
    return r[6] ? 12'd4095 : 12'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [31:0] d, input logic last, input logic [3:0] keep,
                          input logic v);
    axis.tdata  = d;
    axis.tlast  = last;
    axis.tkeep  = keep;
    axis.tvalid = v;
  endtask

  // From IDLE with tvalid high: advance to the last header cycle.
  task automatic run_header(input int osr);
    for (int i = 0; i < 64 * osr; i++) step();
  endtask

  task automatic test_reset();
    cfg_bps = 3'd2;
    cfg_osr = 8'd1;
    set_word(32'h0000_00E4, 1'b1, 4'hF, 1'b1);
    arst_n = 1'b0;
    step();
    step();
    checks++; if (sent_data !== 12'd2048) $display("FAIL rst_data: got %0d want 2048", sent_data); else passes++;
    checks++; if (sent_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", sent_valid); else passes++;
    checks++; if (frame_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", frame_busy); else passes++;
    checks++; if (underrun !== 1'b0) $display("FAIL rst_underrun: got %b want 0", underrun); else passes++;
    checks++; if (axis.tready !== 1'b0) $display("FAIL rst_tready: got %b want 0", axis.tready); else passes++;
    arst_n = 1'b1;
    #1;
    checks++; if (axis.tready !== 1'b0) $display("FAIL idle_tready: got %b want 0", axis.tready); else passes++;
  endtask

  task automatic test_header_pam4();
    logic [11:0] pay [4];
    logic [11:0] e;
    pay[0] = 12'd0; pay[1] = 12'd1365; pay[2] = 12'd4095; pay[3] = 12'd2730;
    for (int k = 0; k < 64; k++) begin
      step();
      e = hdr_exp(k);
      checks++; if (sent_data !== e) $display("FAIL hdr[%0d]: got %0d want %0d", k, sent_data, e); else passes++;
      if (k == 0) begin
        checks++; if (sent_valid !== 1'b1) $display("FAIL hdr_valid: got %b want 1", sent_valid); else passes++;
        checks++; if (frame_busy !== 1'b1) $display("FAIL hdr_busy: got %b want 1", frame_busy); else passes++;
        checks++; if (axis.tready !== 1'b0) $display("FAIL hdr0_tready: got %b want 0", axis.tready); else passes++;
      end
    end
    checks++; if (axis.tready !== 1'b1) $display("FAIL hdr_last_tready: got %b want 1", axis.tready); else passes++;
    step();
    axis.tvalid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) step();
      e = (j < 4) ? pay[j] : 12'd0;
      checks++; if (sent_data !== e) $display("FAIL pam4[%0d]: got %0d want %0d", j, sent_data, e); else passes++;
      checks++; if (sent_valid !== 1'b1) $display("FAIL pam4_valid[%0d]: got %b want 1", j, sent_valid); else passes++;
    end
    for (int g = 0; g < 16; g++) begin
      step();
      checks++; if (sent_data !== 12'd2048 || sent_valid !== 1'b0 || frame_busy !== 1'b1)
        $display("FAIL gap[%0d]: got data %0d valid %b busy %b want 2048 0 1", g, sent_data, sent_valid, frame_busy);
      else passes++;
    end
    step();
    checks++; if (frame_busy !== 1'b0) $display("FAIL pam4_end_busy: got %b want 0", frame_busy); else passes++;
  endtask

  task automatic test_bps4_osr3();
    logic [11:0] pay [4];
    pay[0] = 12'd0; pay[1] = 12'd546; pay[2] = 12'd2730; pay[3] = 12'd4095;
    cfg_bps = 3'd4;
    cfg_osr = 8'd3;
    set_word(32'hFFFF_8F30, 1'b1, 4'b0011, 1'b1);
    run_header(3);
    checks++; if (axis.tready !== 1'b1) $display("FAIL osr3_hdr_tready: got %b want 1", axis.tready); else passes++;
    step();
    axis.tvalid = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) step();
      checks++; if (sent_data !== pay[j/3] || sent_valid !== 1'b1)
        $display("FAIL pam16[%0d]: got %0d/%b want %0d/1", j, sent_data, sent_valid, pay[j/3]);
      else passes++;
    end
    step();
    checks++; if (sent_data !== 12'd2048 || sent_valid !== 1'b0)
      $display("FAIL pam16_gap: got %0d/%b want 2048/0", sent_data, sent_valid);
    else passes++;
    for (int i = 0; i < 16; i++) step();
    checks++; if (frame_busy !== 1'b0) $display("FAIL pam16_end_busy: got %b want 0", frame_busy); else passes++;
  endtask

  task automatic test_underrun();
    cfg_bps = 3'd2;
    cfg_osr = 8'd1;
    set_word(32'h5555_5555, 1'b0, 4'hF, 1'b1);
    run_header(1);
    step();
    axis.tvalid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) step();
      checks++; if (sent_data !== 12'd1365) $display("FAIL ur_w0[%0d]: got %0d want 1365", j, sent_data); else passes++;
      if (j < 15) begin
        checks++; if (axis.tready !== 1'b0) $display("FAIL ur_w0_tready[%0d]: got %b want 0", j, axis.tready); else passes++;
      end
    end
    checks++; if (axis.tready !== 1'b1) $display("FAIL ur_boundary_tready: got %b want 1", axis.tready); else passes++;
    for (int w = 0; w < 5; w++) begin
      step();
      checks++; if (sent_data !== 12'd2048 || sent_valid !== 1'b0 || underrun !== 1'b1 || axis.tready !== 1'b1)
        $display("FAIL ur_wait[%0d]: got %0d/%b/%b/%b want 2048/0/1/1", w, sent_data, sent_valid, underrun, axis.tready);
      else passes++;
    end
    set_word(32'hAAAA_AAAA, 1'b1, 4'hF, 1'b1);
    step();
    axis.tvalid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) step();
      checks++; if (sent_data !== 12'd4095 || sent_valid !== 1'b1)
        $display("FAIL ur_w1[%0d]: got %0d/%b want 4095/1", j, sent_data, sent_valid);
      else passes++;
    end
    checks++; if (underrun !== 1'b1) $display("FAIL ur_sticky: got %b want 1", underrun); else passes++;
    for (int i = 0; i < 17; i++) step();
    checks++; if (frame_busy !== 1'b0) $display("FAIL ur_end_busy: got %b want 0", frame_busy); else passes++;
  endtask

  task automatic test_bps3_bps7();
    logic [11:0] e;
    cfg_bps = 3'd3;
    cfg_osr = 8'd1;
    set_word(32'hC000_0001, 1'b1, 4'hF, 1'b1);
    step();
    checks++; if (underrun !== 1'b0) $display("FAIL ur_cleared: got %b want 0", underrun); else passes++;
    for (int i = 1; i < 64; i++) step();
    step();
    axis.tvalid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) step();
      e = (j == 0) ? 12'd585 : 12'd0;
      checks++; if (sent_data !== e || sent_valid !== 1'b1)
        $display("FAIL pam8[%0d]: got %0d/%b want %0d/1", j, sent_data, sent_valid, e);
      else passes++;
    end
    step();
    checks++; if (sent_data !== 12'd2048 || sent_valid !== 1'b0)
      $display("FAIL pam8_drop: got %0d/%b want 2048/0", sent_data, sent_valid);
    else passes++;
    for (int i = 0; i < 16; i++) step();
    checks++; if (frame_busy !== 1'b0) $display("FAIL pam8_end_busy: got %b want 0", frame_busy); else passes++;

    cfg_bps = 3'd7;
    set_word(32'h0000_0001, 1'b1, 4'hF, 1'b1);
    run_header(1);
    cfg_bps = 3'd4;
    cfg_osr = 8'd5;
    step();
    axis.tvalid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) step();
      e = (j == 0) ? 12'd1365 : 12'd0;
      checks++; if (sent_data !== e || sent_valid !== 1'b1)
        $display("FAIL bps7[%0d]: got %0d/%b want %0d/1", j, sent_data, sent_valid, e);
      else passes++;
    end
    step();
    checks++; if (sent_data !== 12'd2048 || sent_valid !== 1'b0)
      $display("FAIL bps7_gap: got %0d/%b want 2048/0", sent_data, sent_valid);
    else passes++;
    for (int i = 0; i < 16; i++) step();
    cfg_bps = 3'd2;
    cfg_osr = 8'd1;
  endtask

  task automatic test_async_reset();
    logic [11:0] e;
    set_word(32'h5555_5555, 1'b0, 4'hF, 1'b1);
    run_header(1);
    step();
    axis.tvalid = 1'b0;
    for (int j = 1; j < 16; j++) step();
    step();
    set_word(32'hAAAA_AAAA, 1'b0, 4'hF, 1'b1);
    step();
    axis.tvalid = 1'b0;
    step();
    checks++; if (sent_data !== 12'd4095 || underrun !== 1'b1)
      $display("FAIL ar_pre: got %0d/%b want 4095/1", sent_data, underrun);
    else passes++;
    #2;
    arst_n = 1'b0;
    #1;
    checks++; if (sent_data !== 12'd2048) $display("FAIL ar_data: got %0d want 2048", sent_data); else passes++;
    checks++; if (sent_valid !== 1'b0 || frame_busy !== 1'b0)
      $display("FAIL ar_ctrl: got valid %b busy %b want 0 0", sent_valid, frame_busy);
    else passes++;
    checks++; if (underrun !== 1'b0 || axis.tready !== 1'b0)
      $display("FAIL ar_flags: got underrun %b tready %b want 0 0", underrun, axis.tready);
    else passes++;
    step();
    arst_n = 1'b1;
    set_word(32'h0000_0000, 1'b1, 4'hF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      e = hdr_exp(k);
      checks++; if (sent_data !== e) $display("FAIL ar_hdr[%0d]: got %0d want %0d", k, sent_data, e); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_header_pam4();
    test_bps4_osr3();
    test_underrun();
    test_bps3_bps7();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "timeout");
  end

endmodule
